// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: ALU control decoder with a valid/ready handshake and a
// multiply/divide busy sequencer.
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid / in_ready   - request handshake (Instr, ALU_Op sampled on accept)
//   Instr [FUNCT_W]       - R-type funct field (low 6 bits decoded)
//   ALU_Op [2]            - main-decoder ALU class
//   ALU_Control [CTRL_W]  - registered control code
//   illegal               - registered unknown-funct flag
//   out_valid / out_ready - result handshake
//   md_start              - one-cycle pulse in the cycle a mult/div is accepted
//   md_busy               - mult/div op in progress
module alu_ctrl_seq #(
  parameter int FUNCT_W    = 6,
  parameter int CTRL_W     = 4,
  parameter int MD_LATENCY = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FUNCT_W-1:0] Instr,
  input  logic [1:0]         ALU_Op,
  output logic [CTRL_W-1:0]  ALU_Control,
  output logic               illegal,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               md_start,
  output logic               md_busy
);

  localparam int CNT_W = $clog2(MD_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    MD_BUSY
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [5:0] funct;
  logic [3:0] dec_code;
  logic       dec_ill;
  logic       dec_md;
  logic       accept;

  assign funct = Instr[5:0];

  always_comb begin
    dec_code = 4'b0010;
    dec_ill  = 1'b0;
    dec_md   = 1'b0;
    case (ALU_Op)
      2'b00: dec_code = 4'b0010;
      2'b01: dec_code = 4'b0110;
      2'b11: dec_code = 4'b0001;
      default: begin
        case (funct)
          6'b100000: dec_code = 4'b0010;
          6'b100010: dec_code = 4'b0110;
          6'b100100: dec_code = 4'b0000;
          6'b100101: dec_code = 4'b0001;
          6'b100110: dec_code = 4'b0011;
          6'b100111: dec_code = 4'b1100;
          6'b101010: dec_code = 4'b0111;
          6'b011000: begin dec_code = 4'b1000; dec_md = 1'b1; end
          6'b011010: begin dec_code = 4'b1001; dec_md = 1'b1; end
          default:   begin dec_code = 4'b1111; dec_ill = 1'b1; end
        endcase
      end
    endcase
  end

  assign in_ready = (state == IDLE) | ((state == HOLD) & out_ready);
  assign accept   = in_valid & in_ready;
  // Launch pulse coincides with acceptance; reset suppresses it.
  assign md_start = accept & dec_md & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ALU_Control <= '0;
      illegal     <= 1'b0;
      out_valid   <= 1'b0;
      md_busy     <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            ALU_Control <= CTRL_W'(dec_code);
            illegal     <= dec_ill;
            if (dec_md) begin
              state     <= MD_BUSY;
              cnt       <= CNT_W'(MD_LATENCY - 1);
              md_busy   <= 1'b1;
              out_valid <= 1'b0;
            end else begin
              state     <= HOLD;
              out_valid <= 1'b1;
              md_busy   <= 1'b0;
            end
          end else if ((state == HOLD) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        MD_BUSY: begin
          if (cnt == '0) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            md_busy   <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          md_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Testbench for alu_ctrl_seq: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked every cycle against a
// transaction-level model (pending result + remaining busy cycles).
module tb_alu_ctrl_seq;

  localparam int MDL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] Instr = '0;
  logic [1:0] ALU_Op = '0;
  logic [3:0] ALU_Control;
  logic       illegal;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       md_start;
  logic       md_busy;

  int tests  = 0;
  int fails  = 0;
  bit chk_on = 1'b0;

  alu_ctrl_seq #(.FUNCT_W(6), .CTRL_W(4), .MD_LATENCY(MDL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Instr(Instr), .ALU_Op(ALU_Op), .ALU_Control(ALU_Control),
    .illegal(illegal), .out_valid(out_valid), .out_ready(out_ready),
    .md_start(md_start), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [5:0] f);
    // returns {illegal, code}
    if (op == 2'b00) return {1'b0, 4'b0010};
    if (op == 2'b01) return {1'b0, 4'b0110};
    if (op == 2'b11) return {1'b0, 4'b0001};
    case (f)
      6'h20: return {1'b0, 4'b0010};
      6'h22: return {1'b0, 4'b0110};
      6'h24: return {1'b0, 4'b0000};
      6'h25: return {1'b0, 4'b0001};
      6'h26: return {1'b0, 4'b0011};
      6'h27: return {1'b0, 4'b1100};
      6'h2a: return {1'b0, 4'b0111};
      6'h18: return {1'b0, 4'b1000};
      6'h1a: return {1'b0, 4'b1001};
      default: return {1'b1, 4'b1111};
    endcase
  endfunction

  function automatic bit is_md(input logic [1:0] op, input logic [5:0] f);
    return (op == 2'b10) && (f == 6'h18 || f == 6'h1a);
  endfunction

  bit         m_have = 1'b0;   // a result has been registered and not consumed
  int         m_busy = 0;      // cycles left before that result becomes visible
  logic [3:0] m_code = '0;
  logic       m_ill  = 1'b0;

  function automatic bit e_ov();  return m_have && (m_busy == 0); endfunction
  function automatic bit e_mb();  return m_busy != 0;             endfunction
  function automatic bit e_ir();  return !e_mb() && (!m_have || out_ready); endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_have <= 1'b0; m_busy <= 0; m_code <= '0; m_ill <= 1'b0;
    end else begin
      if (m_busy > 0) m_busy <= m_busy - 1;
      if (e_ov() && out_ready) m_have <= 1'b0;
      if (in_valid && e_ir()) begin
        logic [4:0] d;
        d = ref_decode(ALU_Op, Instr);
        m_have <= 1'b1;
        m_code <= d[3:0];
        m_ill  <= d[4];
        m_busy <= is_md(ALU_Op, Instr) ? MDL : 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Compare process: every cycle once reset has been applied.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("in_ready",    32'(in_ready),    32'(e_ir()));
      chk("out_valid",   32'(out_valid),   32'(e_ov()));
      chk("md_busy",     32'(md_busy),     32'(e_mb()));
      chk("md_start",    32'(md_start),
          32'(!rst && in_valid && e_ir() && is_md(ALU_Op, Instr)));
      chk("ALU_Control", 32'(ALU_Control), 32'(m_code));
      chk("illegal",     32'(illegal),     32'(m_ill));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f, input logic ordy);
    in_valid = v; ALU_Op = op; Instr = f; out_ready = ordy;
  endtask

  task automatic at_mid();
    @(negedge clk); #1;
  endtask

  logic [5:0] ftab [9];

  initial begin
    ftab[0] = 6'h20; ftab[1] = 6'h22; ftab[2] = 6'h24; ftab[3] = 6'h25; ftab[4] = 6'h26;
    ftab[5] = 6'h27; ftab[6] = 6'h2a; ftab[7] = 6'h18; ftab[8] = 6'h1a;

    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk_on = 1'b1;
    at_mid();
    chk("rst_ctrl", 32'(ALU_Control), 32'h0);
    chk("rst_ov",   32'(out_valid),   32'h0);
    chk("rst_ir",   32'(in_ready),    32'h1);

    // Single add
    drive(1, 2'b10, 6'h20, 1); step();
    drive(0, 2'b00, 6'h00, 1); at_mid();
    chk("add_ov", 32'(out_valid), 32'h1);
    chk("add_code", 32'(ALU_Control), 32'h2);
    chk("add_ill", 32'(illegal), 32'h0);
    step();

    // Back-to-back sub, slt, nor
    drive(1, 2'b10, 6'h22, 1); step();
    drive(1, 2'b10, 6'h2a, 1); at_mid();
    chk("b2b_sub", 32'(ALU_Control), 32'h6);
    chk("b2b_ir1", 32'(in_ready), 32'h1);
    step();
    drive(1, 2'b10, 6'h27, 1); at_mid();
    chk("b2b_slt", 32'(ALU_Control), 32'h7);
    chk("b2b_ir2", 32'(in_ready), 32'h1);
    step();
    drive(0, 2'b00, 6'h00, 1); at_mid();
    chk("b2b_nor", 32'(ALU_Control), 32'hc);
    chk("b2b_ov", 32'(out_valid), 32'h1);
    step();

    // Divide with latency MDL; new requests during busy must be ignored
    drive(1, 2'b10, 6'h1a, 1); at_mid();
    chk("div_start", 32'(md_start), 32'h1);
    step();
    for (int unsigned c = 1; c <= MDL; c++) begin
      drive(1, 2'b10, 6'h20, 1); at_mid();
      chk("div_busy", 32'(md_busy), 32'h1);
      chk("div_ir",   32'(in_ready), 32'h0);
      chk("div_nost", 32'(md_start), 32'h0);
      step();
    end
    drive(0, 2'b00, 6'h00, 1); at_mid();
    chk("div_ov",   32'(out_valid), 32'h1);
    chk("div_code", 32'(ALU_Control), 32'h9);
    step();

    // Illegal funct then a plain add
    drive(1, 2'b10, 6'h3f, 1); step();
    drive(1, 2'b00, 6'h00, 1); at_mid();
    chk("ill_code", 32'(ALU_Control), 32'hf);
    chk("ill_flag", 32'(illegal), 32'h1);
    step();
    drive(0, 2'b00, 6'h00, 1); at_mid();
    chk("after_ill_code", 32'(ALU_Control), 32'h2);
    chk("after_ill_flag", 32'(illegal), 32'h0);
    step();

    // Backpressure hold
    drive(1, 2'b01, 6'h00, 0); step();
    for (int unsigned c = 0; c < 3; c++) begin
      drive(0, 2'b00, 6'h00, 0); at_mid();
      chk("hold_ov",   32'(out_valid), 32'h1);
      chk("hold_code", 32'(ALU_Control), 32'h6);
      chk("hold_ir",   32'(in_ready), 32'h0);
      step();
    end
    drive(0, 2'b00, 6'h00, 1); at_mid();
    chk("hold_rel_ir", 32'(in_ready), 32'h1);
    step();
    at_mid();
    chk("hold_done_ov", 32'(out_valid), 32'h0);

    // Reset in the middle of MD_BUSY
    drive(1, 2'b10, 6'h18, 1); step();
    drive(0, 2'b00, 6'h00, 1); step();
    rst = 1'b1; step();
    rst = 1'b0; at_mid();
    chk("mrst_ov",   32'(out_valid), 32'h0);
    chk("mrst_mb",   32'(md_busy), 32'h0);
    chk("mrst_code", 32'(ALU_Control), 32'h0);
    chk("mrst_ir",   32'(in_ready), 32'h1);
    drive(1, 2'b00, 6'h00, 1); step();
    drive(0, 2'b00, 6'h00, 1); at_mid();
    chk("mrst_add", 32'(ALU_Control), 32'h2);
    chk("mrst_add_ov", 32'(out_valid), 32'h1);
    step();

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] f;
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ftab[$urandom_range(0, 8)];
      drive(($urandom_range(0, 9) < 7), 2'($urandom), f, ($urandom_range(0, 9) < 7));
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    drive(0, 2'b00, 6'h00, 1);
    step(); step();
    chk_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
